axi4_txn_scheduler: RTL and testbench
=====================================

# axi4_txn_scheduler

Round-robin scheduler that shares the single-transaction AXI4 master FSM between `NUM_REQ` requesters. It accepts one burst request at a time, drives the master's `start`/`addr`/`burst_type`/`rw` control inputs and detects completion by monitoring the AXI B and R channels. It then reports per-transaction completion, with a timeout error, back to the winning requester. It sits directly in front of the AXI4 master FSM's control port.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `ADDR_WIDTH`, 32: request and master address width.
- `TIMEOUT_CYCLES`, 1024: maximum number of WAIT cycles before a transaction is declared hung; ≥2.
- `clk` in 1: the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in NUM_REQ: per-requester request pending.
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_burst` in NUM_REQ*2: packed burst types; 2'b01 = INCR, 2'b10 = WRAP.
- `req_rw` in NUM_REQ: 1 = read, 0 = write.
- `req_ready` out NUM_REQ: one-hot accept strobe.
- `m_start` out 1: start pulse to the master FSM.
- `m_addr` out ADDR_WIDTH: address to the master FSM.
- `m_burst_type` out 2: burst type to the master FSM.
- `m_rw` out 1: direction to the master FSM.
- `mon_bvalid`, `mon_bready` in 1 each: monitored write response handshake.
- `mon_rvalid`, `mon_rready`, `mon_rlast` in 1 each: monitored read data handshake.
- `done_valid` out 1: one-cycle completion strobe.
- `done_id` out $clog2(NUM_REQ): index of the completed requester.
- `done_err` out 1: timeout or illegal-burst error, qualified by `done_valid`.
- `busy` out 1: high whenever the state is not IDLE.
- `hung` out 1: sticky timeout flag; cleared only by reset.

## Operation
- States are IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any `req_valid` is high, pick grant g: the first set bit at or after `rr_ptr`, searching upward with wrap.
  - Assert `req_ready[g]` combinationally for that cycle.
  - At the clock edge:
    - latch g, `req_addr[g]`, `req_burst[g]`, `req_rw[g]`;
    - set `rr_ptr <= (g+1) mod NUM_REQ`.
  - Next state is ISSUE, unless the burst is illegal (2'b00 or 2'b11). In that case go to DONE with the error set, and never assert `m_start`.
- **ISSUE**
  - `m_start = 1` for exactly this one cycle.
  - Next state is WAIT; the timeout counter clears to 0.
- **WAIT**
  - Write completes on `mon_bvalid && mon_bready`.
  - Read completes on `mon_rvalid && mon_rready && mon_rlast`.
  - The handshake of the opposite direction is ignored.
  - The counter increments by 1 every WAIT cycle without completion. When it reaches TIMEOUT_CYCLES-1, go to DONE with the error set and set `hung`.
  - If completion and timeout occur in the same cycle, completion wins and the error is 0.
- **DONE**
  - `done_valid = 1`, `done_id` = latched g, `done_err` = error flag.
  - Next state is always IDLE.
- `m_addr`, `m_burst_type` and `m_rw` are registered and hold the latched values from ISSUE through DONE. The master reads its address combinationally throughout the burst, so these must stay stable.
- Arithmetic and widths:
  - `rr_ptr` is $clog2(NUM_REQ) bits and wraps modulo NUM_REQ; non-power-of-two NUM_REQ is handled explicitly.
  - The timeout counter is $clog2(TIMEOUT_CYCLES) bits and never wraps.
- A requester whose `req_valid` drops before it is granted is simply skipped. `req_valid` is not required to be sticky.

## Timing
- Reset values: all outputs 0, state IDLE, `rr_ptr` 0, `hung` 0. `m_addr`, `m_burst_type` and `m_rw` are 0.
- Reset asserted mid-transaction returns to IDLE on the next edge with no `done_valid`. The aborted requester must re-request.
- Latency for a legal request with continuous handshakes:
  - grant in IDLE at cycle 0;
  - `m_start` at cycle 1;
  - WAIT from cycle 2;
  - `done_valid` one cycle after the completing handshake;
  - IDLE one cycle later.
- Minimum spacing between consecutive `m_start` pulses is completion + 3 cycles. This guarantees the master has returned to IDLE before it sees the next start.
- An illegal burst produces `done_valid` one cycle after the grant (cycle 1).
- Accept handshake: `req_ready[i]` is never high outside IDLE, and is never high for more than one bit.

## Structure
- Shared package `axi4_pkg` holds:
  - burst encodings `BURST_INCR` = 2'b01 and `BURST_WRAP` = 2'b10;
  - a `burst_legal` function;
  - the scheduler state enum `sched_state_t`.
- One sub-module, `rr_arbiter`: purely combinational. Takes `req_valid` and `rr_ptr`; produces a one-hot grant, its index, and an any-grant flag.
- The scheduler holds the FSM, latches, timeout counter and `hung` flag. Target size is roughly 200 lines.

## Test plan
- **Single write:** req0 writes addr 0x1000 INCR.
  - Expect `m_start` at cycle 1 with `m_addr` 0x1000.
  - `bvalid` at cycle 20 → `done_valid` with id 0, err 0 at cycle 21.
- **Round-robin:** `req_valid` = 4'b1111 held high.
  - Grant order 0,1,2,3,0.
  - Exactly one `m_start` per transaction.
  - `rr_ptr` wraps 3 → 0.
- **Read with WRAP:** req2 reads addr 0x1234 WRAP.
  - `m_burst_type` 2'b10, `m_rw` 1.
  - `rvalid` without `rlast` does not complete; `rlast` beat → done with id 2.
- **Illegal burst:** req1 with burst 2'b11.
  - No `m_start`; done with id 1, err 1 at cycle 1; the next requester is then serviced.
- **Timeout:** TIMEOUT_CYCLES = 8 with no B response.
  - done with err 1 after 8 WAIT cycles; `hung` = 1.
  - Variant: completion on the final counter cycle → err 0, `hung` stays 0.
- **Reset mid-WAIT:** pulse `rst_n` low for one edge.
  - All outputs 0, `rr_ptr` 0, no `done_valid`; a new request is then accepted normally.

Source files
------------

// File: rtl/axi4_pkg.sv
// axi4_pkg: definitions shared by the transaction scheduler and its arbiter.
//   BURST_INCR / BURST_WRAP : AXI burst encodings accepted by the scheduler
//   burst_legal()           : true for the two burst types the master supports
//   sched_state_t           : scheduler FSM states
package axi4_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } sched_state_t;

  // FIXED (2'b00) and the reserved encoding (2'b11) are rejected.
  function automatic logic burst_legal(input logic [1:0] burst);
    return (burst == BURST_INCR) || (burst == BURST_WRAP);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
//   req_valid    in  NUM_REQ : pending requests
//   rr_ptr       in  IDX_W   : highest-priority requester this round
//   grant_onehot out NUM_REQ : one-hot grant (all zero when nothing pending)
//   grant_idx    out IDX_W   : index of the granted requester
//   grant_any    out 1       : at least one request is pending
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  // One extra bit so rr_ptr + offset cannot overflow before the explicit
  // modulo, which keeps non-power-of-two NUM_REQ correct.
  logic [IDX_W:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid requester
  // (first at or after rr_ptr, with wrap) is the last one written.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
        cand = cand - (IDX_W + 1)'(NUM_REQ);
      end
      if (req_valid[cand[IDX_W-1:0]]) begin
        grant_idx = cand[IDX_W-1:0];
        grant_any = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign grant_onehot[gi] = grant_any && (grant_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/axi4_txn_scheduler.sv
// axi4_txn_scheduler: round-robin sharing of a single-transaction AXI4 master.
//   clk, rst_n                  : clock, synchronous active-low reset
//   req_valid/addr/burst/rw     : packed per-requester burst requests
//   req_ready                   : one-hot accept strobe (IDLE only)
//   m_start/addr/burst_type/rw  : control port of the AXI4 master FSM
//   mon_b*, mon_r*              : monitored B / R handshakes for completion
//   done_valid/id/err           : one-cycle completion report to the winner
//   busy                        : a transaction is in flight
//   hung                        : sticky timeout indicator
module axi4_txn_scheduler
  import axi4_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*2-1:0]          req_burst,
  input  logic [NUM_REQ-1:0]            req_rw,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          m_start,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [1:0]                    m_burst_type,
  output logic                          m_rw,
  input  logic                          mon_bvalid,
  input  logic                          mon_bready,
  input  logic                          mon_rvalid,
  input  logic                          mon_rready,
  input  logic                          mon_rlast,
  output logic                          done_valid,
  output logic [$clog2(NUM_REQ)-1:0]    done_id,
  output logic                          done_err,
  output logic                          busy,
  output logic                          hung
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  sched_state_t          state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      gnt_id_q, gnt_id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            burst_q, burst_d;
  logic                  rw_q, rw_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  hung_q, hung_d;

  logic [NUM_REQ-1:0]    grant_onehot;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  complete;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [1:0]            burst_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign burst_arr[gi] = req_burst[gi*2 +: 2];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_valid    (req_valid),
    .rr_ptr       (rr_ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_any    (grant_any)
  );

  // Only the handshake matching the latched direction can end a burst.
  assign complete = rw_q ? (mon_rvalid && mon_rready && mon_rlast)
                         : (mon_bvalid && mon_bready);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_id_d   = gnt_id_q;
    addr_d     = addr_q;
    burst_d    = burst_q;
    rw_d       = rw_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    hung_d     = hung_q;
    req_ready  = '0;
    m_start    = 1'b0;
    done_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          req_ready = grant_onehot;
          gnt_id_d  = grant_idx;
          addr_d    = addr_arr[grant_idx];
          burst_d   = burst_arr[grant_idx];
          rw_d      = req_rw[grant_idx];
          rr_ptr_d  = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
          if (burst_legal(burst_arr[grant_idx])) begin
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end else begin
            // Illegal burst never reaches the master.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        m_start = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion is tested first so it wins over a same-cycle timeout.
        if (complete) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          hung_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        done_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_id_q <= '0;
      addr_q   <= '0;
      burst_q  <= '0;
      rw_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      hung_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_id_q <= gnt_id_d;
      addr_q   <= addr_d;
      burst_q  <= burst_d;
      rw_q     <= rw_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      hung_q   <= hung_d;
    end
  end

  assign m_addr       = addr_q;
  assign m_burst_type = burst_q;
  assign m_rw         = rw_q;
  assign done_id      = gnt_id_q;
  assign done_err     = done_valid && err_q;
  assign busy         = (state_q != ST_IDLE);
  assign hung         = hung_q;

endmodule

// File: tb/tb_axi4_txn_scheduler.sv
// Bench for axi4_txn_scheduler. dut_a uses the default timeout, dut_b uses
// TIMEOUT_CYCLES = 8; both share the same stimulus. Completion expectations
// go into exp_q at grant time and are popped when done_valid appears.
module tb_axi4_txn_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_addr;
  logic [7:0]   req_burst;
  logic [3:0]   req_rw;
  logic         mon_bvalid, mon_bready, mon_rvalid, mon_rready, mon_rlast;

  logic [3:0]  a_req_ready, b_req_ready;
  logic        a_m_start, b_m_start;
  logic [31:0] a_m_addr, b_m_addr;
  logic [1:0]  a_m_burst_type, b_m_burst_type;
  logic        a_m_rw, b_m_rw;
  logic        a_done_valid, b_done_valid;
  logic [1:0]  a_done_id, b_done_id;
  logic        a_done_err, b_done_err;
  logic        a_busy, b_busy;
  logic        a_hung, b_hung;

  typedef struct packed {
    logic [1:0] id;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   a_starts = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (a_m_start) a_starts <= a_starts + 1;

  axi4_txn_scheduler dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_burst(req_burst), .req_rw(req_rw), .req_ready(a_req_ready),
    .m_start(a_m_start), .m_addr(a_m_addr), .m_burst_type(a_m_burst_type),
    .m_rw(a_m_rw), .mon_bvalid(mon_bvalid), .mon_bready(mon_bready),
    .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rlast(mon_rlast),
    .done_valid(a_done_valid), .done_id(a_done_id), .done_err(a_done_err),
    .busy(a_busy), .hung(a_hung)
  );

  axi4_txn_scheduler #(.TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_burst(req_burst), .req_rw(req_rw), .req_ready(b_req_ready),
    .m_start(b_m_start), .m_addr(b_m_addr), .m_burst_type(b_m_burst_type),
    .m_rw(b_m_rw), .mon_bvalid(mon_bvalid), .mon_bready(mon_bready),
    .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rlast(mon_rlast),
    .done_valid(b_done_valid), .done_id(b_done_id), .done_err(b_done_err),
    .busy(b_busy), .hung(b_hung)
  );

  task automatic set_req(input int i, input logic [31:0] a, input logic [1:0] b,
                         input logic rw);
    req_addr[i*32 +: 32] = a;
    req_burst[i*2 +: 2]  = b;
    req_rw[i]            = rw;
  endtask

  // Ends on the negedge where dut_a shows done_valid, or after budget cycles.
  task automatic wait_done_a(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (a_done_valid) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; req_burst = '0; req_rw = '0;
    mon_bvalid = 0; mon_bready = 0; mon_rvalid = 0; mon_rready = 0; mon_rlast = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({a_m_start, a_m_addr, a_m_burst_type, a_m_rw, a_done_valid, a_done_id,
         a_done_err, a_busy, a_hung, a_req_ready} !== '0)
      $display("FAIL reset_outputs: start=%0b addr=%h burst=%0d rw=%0b dv=%0b id=%0d err=%0b busy=%0b hung=%0b ready=%b, required all 0",
               a_m_start, a_m_addr, a_m_burst_type, a_m_rw, a_done_valid, a_done_id,
               a_done_err, a_busy, a_hung, a_req_ready);
    else n_pass++;
    n_checks++;
    if (dut_a.rr_ptr_q !== 2'd0) $display("FAIL reset_rr_ptr: got %0d, required 0", dut_a.rr_ptr_q);
    else n_pass++;
    $display("txn reset: outputs checked");
  endtask

  task automatic test_single_write();
    exp_t e;
    bit bad;
    do_reset();
    req_valid = 4'b0001;
    set_req(0, 32'h1000, 2'b01, 1'b0);
    #1;
    n_checks++;
    if (a_req_ready !== 4'b0001) $display("FAIL wr_ready: got %b, required 0001", a_req_ready);
    else n_pass++;
    exp_q.push_back('{id: 2'd0, err: 1'b0});
    @(negedge clk); // cycle 1
    req_valid = '0;
    n_checks++;
    if (a_m_start !== 1'b1 || a_m_addr !== 32'h1000 || a_m_rw !== 1'b0 || a_m_burst_type !== 2'b01)
      $display("FAIL wr_issue: start=%0b addr=%h rw=%0b burst=%0d, required 1 00001000 0 1",
               a_m_start, a_m_addr, a_m_rw, a_m_burst_type);
    else n_pass++;
    bad = 1'b0;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (a_done_valid || a_m_start || a_m_addr !== 32'h1000) bad = 1'b1;
      if (c == 20) begin mon_bvalid = 1'b1; mon_bready = 1'b1; end
    end
    n_checks++;
    if (bad) $display("FAIL wr_wait: early done/start or unstable m_addr, required none before cycle 21");
    else n_pass++;
    @(negedge clk); // cycle 21
    mon_bvalid = 1'b0; mon_bready = 1'b0;
    n_checks++;
    if (a_done_valid !== 1'b1 || exp_q.size() == 0)
      $display("FAIL wr_done: done_valid=%0b queued=%0d at cycle 21, required 1 and 1", a_done_valid, exp_q.size());
    else begin
      n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if (a_done_id !== e.id || a_done_err !== e.err)
        $display("FAIL wr_done_id: got id=%0d err=%0b, required id=%0d err=%0b", a_done_id, a_done_err, e.id, e.err);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (a_busy !== 1'b0) $display("FAIL wr_idle: busy=%0b, required 0", a_busy);
    else n_pass++;
    $display("txn single_write: id=%0d err=%0b", a_done_id, a_done_err);
  endtask

  task automatic test_round_robin();
    exp_t e;
    bit seen;
    int s0;
    do_reset();
    mon_bvalid = 1'b1; mon_bready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 32'h100 * i, 2'b01, 1'b0);
    req_valid = 4'b1111;
    s0 = a_starts;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (a_req_ready !== (4'b0001 << (k % 4)))
        $display("FAIL rr_grant%0d: ready=%b, required %b", k, a_req_ready, 4'b0001 << (k % 4));
      else n_pass++;
      exp_q.push_back('{id: 2'(k % 4), err: 1'b0});
      wait_done_a(10, seen);
      n_checks++;
      if (!seen || exp_q.size() == 0) $display("FAIL rr_done%0d: seen=%0b, required 1", k, seen);
      else begin
        n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (a_done_id !== e.id || a_done_err !== e.err)
          $display("FAIL rr_id%0d: got id=%0d err=%0b, required id=%0d err=%0b", k, a_done_id, a_done_err, e.id, e.err);
        else n_pass++;
      end
      $display("txn rr k=%0d: id=%0d", k, a_done_id);
      if (k == 3) begin
        n_checks++;
        if (dut_a.rr_ptr_q !== 2'd0) $display("FAIL rr_wrap: rr_ptr=%0d, required 0", dut_a.rr_ptr_q);
        else n_pass++;
      end
      @(negedge clk);
      if (k == 4) req_valid = '0;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (a_starts - s0 !== 5) $display("FAIL rr_starts: got %0d, required 5", a_starts - s0);
    else n_pass++;
  endtask

  task automatic test_read_wrap();
    exp_t e;
    bit bad;
    do_reset();
    mon_bvalid = 1'b1; mon_bready = 1'b1; // write response must be ignored
    set_req(2, 32'h1234, 2'b10, 1'b1);
    req_valid = 4'b0100;
    #1;
    n_checks++;
    if (a_req_ready !== 4'b0100) $display("FAIL rd_ready: got %b, required 0100", a_req_ready);
    else n_pass++;
    exp_q.push_back('{id: 2'd2, err: 1'b0});
    @(negedge clk); // cycle 1
    req_valid = '0;
    n_checks++;
    if (a_m_start !== 1'b1 || a_m_addr !== 32'h1234 || a_m_burst_type !== 2'b10 || a_m_rw !== 1'b1)
      $display("FAIL rd_issue: start=%0b addr=%h burst=%0d rw=%0b, required 1 00001234 2 1",
               a_m_start, a_m_addr, a_m_burst_type, a_m_rw);
    else n_pass++;
    mon_rvalid = 1'b1; mon_rready = 1'b1; mon_rlast = 1'b0;
    bad = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      if (a_done_valid) bad = 1'b1;
      if (c == 5) mon_rlast = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL rd_nolast: done_valid=1 before rlast, required 0");
    else n_pass++;
    @(negedge clk); // cycle 6
    mon_rvalid = 1'b0; mon_rready = 1'b0; mon_rlast = 1'b0;
    n_checks++;
    if (a_done_valid !== 1'b1 || exp_q.size() == 0)
      $display("FAIL rd_done: done_valid=%0b, required 1", a_done_valid);
    else begin
      n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if (a_done_id !== e.id || a_done_err !== e.err)
        $display("FAIL rd_done_id: got id=%0d err=%0b, required id=%0d err=%0b", a_done_id, a_done_err, e.id, e.err);
      else n_pass++;
    end
    $display("txn read_wrap: id=%0d err=%0b", a_done_id, a_done_err);
  endtask

  task automatic test_illegal_burst();
    exp_t e;
    bit seen;
    int s0;
    do_reset();
    mon_bvalid = 1'b1; mon_bready = 1'b1;
    set_req(1, 32'h2000, 2'b11, 1'b0);
    set_req(2, 32'h2200, 2'b01, 1'b0);
    req_valid = 4'b0110;
    s0 = a_starts;
    #1;
    n_checks++;
    if (a_req_ready !== 4'b0010) $display("FAIL ill_ready: got %b, required 0010", a_req_ready);
    else n_pass++;
    exp_q.push_back('{id: 2'd1, err: 1'b1});
    @(negedge clk); // cycle 1
    req_valid = 4'b0100;
    n_checks++;
    if (a_done_valid !== 1'b1 || a_m_start !== 1'b0 || exp_q.size() == 0)
      $display("FAIL ill_done: done_valid=%0b start=%0b at cycle 1, required 1 0", a_done_valid, a_m_start);
    else begin
      n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if (a_done_id !== e.id || a_done_err !== e.err)
        $display("FAIL ill_done_id: got id=%0d err=%0b, required id=%0d err=%0b", a_done_id, a_done_err, e.id, e.err);
      else n_pass++;
    end
    @(negedge clk); // cycle 2, IDLE again
    #1;
    n_checks++;
    if (a_req_ready !== 4'b0100) $display("FAIL ill_next_ready: got %b, required 0100", a_req_ready);
    else n_pass++;
    exp_q.push_back('{id: 2'd2, err: 1'b0});
    wait_done_a(10, seen);
    req_valid = '0;
    n_checks++;
    if (!seen || exp_q.size() == 0) $display("FAIL ill_next_done: seen=%0b, required 1", seen);
    else begin
      n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if (a_done_id !== e.id || a_done_err !== e.err)
        $display("FAIL ill_next_id: got id=%0d err=%0b, required id=%0d err=%0b", a_done_id, a_done_err, e.id, e.err);
      else n_pass++;
    end
    n_checks++;
    if (a_starts - s0 !== 1) $display("FAIL ill_starts: got %0d, required 1", a_starts - s0);
    else n_pass++;
    $display("txn illegal_burst: next id=%0d", a_done_id);
  endtask

  // dut_b (TIMEOUT_CYCLES = 8); complete_last completes on the final WAIT cycle.
  task automatic test_timeout(input bit complete_last);
    exp_t e;
    bit bad;
    do_reset();
    set_req(0, 32'h4000, 2'b01, 1'b0);
    req_valid = 4'b0001;
    exp_q.push_back('{id: 2'd0, err: !complete_last});
    @(negedge clk); // cycle 1
    req_valid = '0;
    bad = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      if (b_done_valid || b_hung) bad = 1'b1;
      if (c == 9 && complete_last) begin mon_bvalid = 1'b1; mon_bready = 1'b1; end
    end
    n_checks++;
    if (bad) $display("FAIL to_wait%0d: done/hung before 8 WAIT cycles, required none", complete_last);
    else n_pass++;
    @(negedge clk); // cycle 10
    mon_bvalid = 1'b0; mon_bready = 1'b0;
    n_checks++;
    if (b_done_valid !== 1'b1 || exp_q.size() == 0)
      $display("FAIL to_done%0d: done_valid=%0b at cycle 10, required 1", complete_last, b_done_valid);
    else begin
      n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if (b_done_id !== e.id || b_done_err !== e.err || b_hung !== e.err)
        $display("FAIL to_err%0d: id=%0d err=%0b hung=%0b, required id=%0d err=%0b hung=%0b",
                 complete_last, b_done_id, b_done_err, b_hung, e.id, e.err, e.err);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (b_busy !== 1'b0 || b_hung !== !complete_last)
      $display("FAIL to_sticky%0d: busy=%0b hung=%0b, required 0 %0b", complete_last, b_busy, b_hung, !complete_last);
    else n_pass++;
    $display("txn timeout variant=%0d: err=%0b hung=%0b", complete_last, b_done_err, b_hung);
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    bit bad;
    bit seen;
    do_reset();
    set_req(0, 32'h5000, 2'b10, 1'b0);
    req_valid = 4'b0001;
    exp_q.push_back('{id: 2'd0, err: 1'b0});
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk); // cycle 5, in WAIT
    rst_n = 1'b0;
    exp_q.delete(); // aborted transaction never reports
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({a_m_start, a_m_addr, a_m_burst_type, a_m_rw, a_done_valid, a_busy, a_req_ready} !== '0)
      $display("FAIL rst_mid_out: start=%0b addr=%h burst=%0d rw=%0b dv=%0b busy=%0b, required all 0",
               a_m_start, a_m_addr, a_m_burst_type, a_m_rw, a_done_valid, a_busy);
    else n_pass++;
    n_checks++;
    if (dut_a.rr_ptr_q !== 2'd0) $display("FAIL rst_mid_ptr: rr_ptr=%0d, required 0", dut_a.rr_ptr_q);
    else n_pass++;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (a_done_valid) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL rst_mid_nodone: done_valid after reset, required 0");
    else n_pass++;
    mon_bvalid = 1'b1; mon_bready = 1'b1;
    set_req(3, 32'h3000, 2'b01, 1'b0);
    req_valid = 4'b1000;
    #1;
    n_checks++;
    if (a_req_ready !== 4'b1000) $display("FAIL rst_mid_ready: got %b, required 1000", a_req_ready);
    else n_pass++;
    exp_q.push_back('{id: 2'd3, err: 1'b0});
    @(negedge clk);
    req_valid = '0;
    wait_done_a(10, seen);
    n_checks++;
    if (!seen || exp_q.size() == 0) $display("FAIL rst_mid_done: seen=%0b, required 1", seen);
    else begin
      n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if (a_done_id !== e.id || a_done_err !== e.err)
        $display("FAIL rst_mid_id: got id=%0d err=%0b, required id=%0d err=%0b", a_done_id, a_done_err, e.id, e.err);
      else n_pass++;
    end
    $display("txn reset_mid_wait: new id=%0d", a_done_id);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; req_burst = '0; req_rw = '0;
    mon_bvalid = 0; mon_bready = 0; mon_rvalid = 0; mon_rready = 0; mon_rlast = 0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_wrap();
    test_illegal_burst();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

endmodule
